// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the memory/write-back stage
package core_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef struct packed {
    logic [MEM_AW-1:0]   addr;
    logic [MEM_DW/8-1:0] be;
    logic [MEM_DW-1:0]   wdata;
    logic                we;
  } mem_req_t;

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - store lane/byte-enable generation, load extraction, access checks
module lsu_data_align
  import core_pkg::*;
(
  input  logic [2:0]        st_funct3_i,
  input  logic [1:0]        st_off_i,
  input  logic [MEM_DW-1:0] st_data_i,
  input  logic              st_read_i,
  input  logic              st_write_i,
  output logic [3:0]        st_be_o,
  output logic [MEM_DW-1:0] st_wdata_o,
  output logic              st_err_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [MEM_DW-1:0] ld_rdata_i,
  output logic [MEM_DW-1:0] ld_data_o
);

  logic misaligned;
  logic illegal;
  logic [MEM_DW-1:0] lane_b;
  logic [MEM_DW-1:0] lane_h;

  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = st_data_i;
    misaligned = 1'b0;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
        misaligned = st_off_i[0];
      end
      2'b10: begin
        st_be_o    = 4'b1111;
        misaligned = (st_off_i != 2'b00);
      end
      default: st_be_o = 4'b0000;
    endcase
    // 011/111 fall in the default size slot; 110 would be an unsigned word
    illegal  = (st_funct3_i[1:0] == 2'b11) || (st_funct3_i == 3'b110)
               || (st_read_i && st_write_i);
    st_err_o = misaligned || illegal;
  end

  always_comb begin
    lane_b = ld_rdata_i >> {ld_off_i, 3'b000};
    lane_h = ld_rdata_i >> {ld_off_i[1], 4'b0000};
    case (ld_funct3_i)
      LSU_B:   ld_data_o = {{24{lane_b[7]}}, lane_b[7:0]};
      LSU_H:   ld_data_o = {{16{lane_h[15]}}, lane_h[15:0]};
      LSU_BU:  ld_data_o = {24'h0, lane_b[7:0]};
      LSU_HU:  ld_data_o = {16'h0, lane_h[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_unit.sv
// rtl/mem_wb_unit.sv - load/store sequencing and register-file write-back
module mem_wb_unit
  import core_pkg::*;
#(
  parameter int DATA_WIDTH     = MEM_DW,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_WIDTH     = MEM_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_i,
  input  logic                      ex_reg_write_i,
  input  logic                      ex_mem_read_i,
  input  logic                      ex_mem_write_i,
  input  logic [2:0]                ex_funct3_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result_i,
  input  logic [DATA_WIDTH-1:0]     ex_rs2_data_i,
  output logic                      stall_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
  output logic [DATA_WIDTH/8-1:0]   dmem_be_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic                      wb_reg_write_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_wr_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_wr_data_o,
  output logic                      err_o
);

  mem_state_e state_q, state_d;
  logic [2:0] funct3_q, funct3_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [1:0] off_q, off_d;
  mem_req_t req_q, req_d;
  logic wb_we_q, wb_we_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic err_q, err_d;

  logic [3:0] st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic st_err;
  logic [DATA_WIDTH-1:0] ld_data;
  logic is_mem;

  lsu_data_align u_align (
    .st_funct3_i (ex_funct3_i),
    .st_off_i    (ex_alu_result_i[1:0]),
    .st_data_i   (ex_rs2_data_i),
    .st_read_i   (ex_mem_read_i),
    .st_write_i  (ex_mem_write_i),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .st_err_o    (st_err),
    .ld_funct3_i (funct3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (dmem_rdata_i),
    .ld_data_o   (ld_data)
  );

  assign is_mem = ex_mem_read_i || ex_mem_write_i;

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    off_d     = off_q;
    req_d     = req_q;
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            wb_we_d   = ex_reg_write_i && (ex_rd_addr_i != '0);
            wb_addr_d = ex_rd_addr_i;
            wb_data_d = ex_alu_result_i;
          end else if (st_err) begin
            err_d = 1'b1;
          end else begin
            state_d     = REQ;
            funct3_d    = ex_funct3_i;
            rd_d        = ex_rd_addr_i;
            off_d       = ex_alu_result_i[1:0];
            req_d.addr  = {ex_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
            req_d.be    = st_be;
            req_d.wdata = st_wdata;
            req_d.we    = ex_mem_write_i;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) state_d = req_q.we ? IDLE : RESP;
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          wb_we_d   = (rd_q != '0);
          wb_addr_d = rd_q;
          wb_data_d = ld_data;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      rd_q      <= '0;
      off_q     <= '0;
      req_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      off_q     <= off_d;
      req_q     <= req_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign stall_o        = (state_q != IDLE);
  assign dmem_req_o     = (state_q == REQ);
  assign dmem_we_o      = req_q.we;
  assign dmem_addr_o    = req_q.addr;
  assign dmem_be_o      = req_q.be;
  assign dmem_wdata_o   = req_q.wdata;
  assign wb_reg_write_o = wb_we_q;
  assign wb_wr_addr_o   = wb_addr_q;
  assign wb_wr_data_o   = wb_data_q;
  assign err_o          = err_q;

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Memory-access plus write-back end of the pipeline.
- Consumes the EX-stage result, performs loads and stores over a req/gnt/rvalid data-memory port, and formats load data.
- Drives the register-file write port (write enable, destination address, write data) that the ID stage consumes.
- Raises a stall to hold the upstream pipeline registers while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and memory data width.
- REG_ADDR_WIDTH, 5, register index width.
- ADDR_WIDTH, 32, data-memory byte address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX result valid this cycle
- ex_reg_write_i  in  1  instruction writes rd
- ex_mem_read_i  in  1  load
- ex_mem_write_i  in  1  store
- ex_funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_rd_addr_i  in  REG_ADDR_WIDTH  destination register
- ex_alu_result_i  in  DATA_WIDTH  result, or effective address for memory ops
- ex_rs2_data_i  in  DATA_WIDTH  store data
- stall_o  out  1  upstream must hold
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address
- dmem_be_o  out  DATA_WIDTH/8  byte enables
- dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  DATA_WIDTH  load data
- wb_reg_write_o  out  1  register-file write enable
- wb_wr_addr_o  out  REG_ADDR_WIDTH  write address
- wb_wr_data_o  out  DATA_WIDTH  write data
- err_o  out  1  one-cycle pulse: misaligned or illegal access

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0.
- The reset value holds while rst_n is low; release is taken on a clk edge.
- States: IDLE, REQ, RESP. stall_o = (state != IDLE), combinational from state.
- Accept rule: ex_valid_i && state==IDLE.
- Non-memory op accepted: next edge registers
  - wb_reg_write_o = ex_reg_write_i && rd!=0
  - wb_wr_addr_o = rd
  - wb_wr_data_o = alu_result
  - Latency 1; back-to-back every cycle.
- Memory op accepted:
  - Capture funct3, rd, addr[1:0], be, wdata.
  - Go to REQ; wb_reg_write_o = 0 next cycle.
- REQ:
  - dmem_req_o = 1; addr/be/wdata/we held stable until the gnt cycle.
  - On dmem_gnt_i: store → IDLE; load → RESP.
- RESP:
  - dmem_req_o = 0.
  - On dmem_rvalid_i: next edge wb_reg_write_o = (rd!=0), wb_wr_data_o = formatted data; state → IDLE.
- Minimum load latency is 3 edges after accept (zero-wait gnt and rvalid).
- Stores never write the register file.
- Store formatting:
  - SB: be = 0001 << a[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << {a[1],0}, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
- Load formatting: select the byte/half lane by a[1:0]; sign-extend for B/H, zero-extend for BU/HU.
- Misaligned accesses (H with a[0]=1, W with a[1:0]!=0): no request, err_o pulse next edge, no write-back, stay IDLE.
- Illegal accesses (funct3 011/110/111 on a memory op, or mem_read && mem_write both set): no request, err_o pulse next edge, no write-back, stay IDLE.
- dmem_rvalid_i in IDLE or REQ is ignored.
- dmem_gnt_i outside REQ is ignored.
- wb_* outputs are single-cycle pulses per instruction; wb_reg_write_o drops to 0 the cycle after unless a new result lands.
- rd = 0: wb_reg_write_o is forced 0; the address and data outputs still update.
- Reset mid-transaction: request abandoned, dmem_req_o drops immediately; any later rvalid is ignored.
- ex_valid_i while stalled: not sampled; upstream holds it.

Decomposition:
- core_pkg gains:
  - mem_state_e enum (IDLE/REQ/RESP)
  - funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - a mem_req_t struct (addr, be, wdata, we)
- Sub-module lsu_data_align, purely combinational:
  - store path: be and wdata generation
  - load path: lane extraction and extension
  - misaligned/illegal flagging
- The FSM and pipeline registers stay in mem_wb_unit.

Test Plan:
- ALU op: alu_result=0x1234_5678, rd=5, reg_write=1 → next cycle wb_reg_write_o=1, addr 5, data 0x1234_5678, stall_o=0 throughout.
- SB addr 0x0000_0103, rs2=0xAABB_CCDD, gnt after 2 wait cycles → dmem_addr_o 0x100, be 1000, wdata 0xDDDD_DDDD held for 3 cycles; stall_o high 3 cycles; no WB write.
- LB addr 0x202, rdata 0x0080_0000 → wb_wr_data_o 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU addr 0x202, rdata 0x8001_0000 → 0x0000_8001.
- LW addr 0x0000_0006 → err_o pulse, dmem_req_o never asserted, wb_reg_write_o=0, stall_o=0.
- LW to rd=0 with rvalid → no register write; a stray rvalid in IDLE → ignored, no WB.
- rst_n low while in RESP → dmem_req_o/stall_o 0 at once; rvalid arriving after release → no write.
